// File: rtl/booth_pkg.sv
// Shared constants for the booth operand sequencer: FSM state encoding and default widths.
package booth_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/booth_ext.sv
// Combinational multiplicand extender for the booth core.
// Sign-extends when BOOTH_SEQ_SIGNED_EN is defined, zero-extends otherwise.
module booth_ext #(
  parameter int WIDTH = booth_pkg::WIDTH_DEF
) (
  input  logic [WIDTH-1:0]   a_i,
  output logic [2*WIDTH-1:0] ext_o
);

`ifdef BOOTH_SEQ_SIGNED_EN
  assign ext_o = {{WIDTH{a_i[WIDTH-1]}}, a_i};
`else
  assign ext_o = {{WIDTH{1'b0}}, a_i};
`endif

endmodule

// File: rtl/booth_seq.sv
// Operand sequencer for the booth multiplier core: accepts operands, steps the core
// through WIDTH iterations and hands the captured product downstream. Honours BOOTH_SEQ_SIGNED_EN.
module booth_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic [2*WIDTH-1:0] multiplicand,
  output logic [WIDTH-1:0]   multiplier,
  output logic [CNT_W-1:0]   count,
  output logic               core_reset,
  input  logic [2*WIDTH-1:0] result_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(WIDTH);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 in_ready_q, in_ready_d;
  logic                 busy_q, busy_d;
  logic                 out_valid_q, out_valid_d;
  logic                 core_reset_q, core_reset_d;
  logic [2*WIDTH-1:0]   a_ext;

  booth_ext #(.WIDTH(WIDTH)) u_ext (
    .a_i   (a_in),
    .ext_o (a_ext)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          mplier_d = b_in;
          mcand_d  = a_ext;
          count_d  = '0;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        count_d = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (count_q == CNT_LAST) begin
          count_d = CNT_END;
          state_d = ST_CAPTURE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      ST_CAPTURE: begin
        product_d = result_out;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          count_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Handshake and core-control outputs are registered, so derive them from the next state.
    in_ready_d   = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
    out_valid_d  = (state_d == ST_DONE);
    core_reset_d = !((state_d == ST_RUN) || (state_d == ST_CAPTURE));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      product_q    <= '0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      product_q    <= product_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
      core_reset_q <= core_reset_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign busy         = busy_q;
  assign out_valid    = out_valid_q;
  assign core_reset   = core_reset_q;
  assign count        = count_q;
  assign multiplicand = mcand_q;
  assign multiplier   = mplier_q;
  assign product      = product_q;

endmodule

// File: tb/tb_booth_seq.sv
// Self-checking bench for booth_seq with a behavioural booth core model.
// Expected extension follows BOOTH_SEQ_SIGNED_EN, matching the DUT build.
module tb_booth_seq;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a_in;
  logic [3:0] b_in;
  logic [7:0] multiplicand;
  logic [3:0] multiplier;
  logic [2:0] count;
  logic       core_reset;
  logic [7:0] result_out;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] product;
  logic       busy;

  int compareCount  = 0;
  int mismatchCount = 0;

  booth_seq dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a_in         (a_in),
    .b_in         (b_in),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .count        (count),
    .core_reset   (core_reset),
    .result_out   (result_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Core model: the finished product only appears once all iterations are done; otherwise a marker value.
  always_comb begin
    if (count == 3'd4 && !core_reset)
      result_out = 8'(multiplicand * {{4{multiplier[3]}}, multiplier});
    else
      result_out = 8'hA5;
  end

  function automatic logic [7:0] extA(input logic [3:0] a);
`ifdef BOOTH_SEQ_SIGNED_EN
    return {{4{a[3]}}, a};
`else
    return {4'b0000, a};
`endif
  endfunction

  function automatic logic [7:0] refProduct(input logic [3:0] a, input logic [3:0] b);
    int prod;
`ifdef BOOTH_SEQ_SIGNED_EN
    prod = int'($signed(a)) * int'($signed(b));
`else
    prod = int'(a) * int'($signed(b));
`endif
    return 8'(prod);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One full transaction: accept, step through the core, hold in DONE for holdCycles, then release.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                               input logic [7:0] expProd, input int holdCycles);
    int lat;
    int expCnt[6] = '{0, 0, 1, 2, 3, 4};
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_in     = 4'($urandom);
    b_in     = 4'($urandom);
    checkOutput("multiplicand", 32'(multiplicand), 32'(extA(a)));
    checkOutput("multiplier", 32'(multiplier), 32'(b));
    checkOutput("in_ready_load", 32'(in_ready), 32'd0);
    lat = 0;
    checkOutput("count_seq", 32'(count), 32'(expCnt[0]));
    checkOutput("core_reset_seq", 32'(core_reset), 32'd1);
    while (!out_valid && lat < 20) begin
      out_ready = (lat < 5) ? 1'($urandom) : 1'b0;
      if (lat > 0 && lat < 4) begin
        a_in = 4'($urandom);
        b_in = 4'($urandom);
      end
      @(posedge clk); #1;
      lat++;
      if (lat <= 5) begin
        checkOutput("count_seq", 32'(count), 32'(expCnt[lat]));
        checkOutput("core_reset_seq", 32'(core_reset), 32'd0);
      end
    end
    out_ready = 1'b0;
    checkOutput("latency", 32'(lat), 32'd6);
    checkOutput("product", 32'(product), 32'(expProd));
    checkOutput("busy_done", 32'(busy), 32'd1);
    for (int i = 0; i < holdCycles; i++) begin
      in_valid = 1'b1;
      a_in     = 4'($urandom);
      b_in     = 4'($urandom);
      @(posedge clk); #1;
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_product", 32'(product), 32'(expProd));
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("release_valid", 32'(out_valid), 32'd0);
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);
    checkOutput("release_count", 32'(count), 32'd0);
    checkOutput("release_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] ra, rb;
    int waitCycles;
    reset     = 1'b0;
    in_valid  = 1'b1;
    a_in      = 4'hF;
    b_in      = 4'hF;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_multiplicand", 32'(multiplicand), 32'd0);
    checkOutput("rst_multiplier", 32'(multiplier), 32'd0);
    checkOutput("rst_product", 32'(product), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_core_reset", 32'(core_reset), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk); #1;

    applyStimulus(4'b0101, 4'b0111, 8'd35, 0);
`ifdef BOOTH_SEQ_SIGNED_EN
    applyStimulus(4'b1101, 4'b0011, 8'hF7, 2);
`else
    applyStimulus(4'b1101, 4'b0011, 8'd39, 2);
`endif
    applyStimulus(4'b1001, 4'b0110, refProduct(4'b1001, 4'b0110), 10);

    // Abort an operation mid-run; nothing may come out of it.
    in_valid = 1'b1;
    a_in     = 4'd9;
    b_in     = 4'd6;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    waitCycles = 0;
    while (!(count == 3'd2 && !core_reset) && waitCycles < 10) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    checkOutput("abort_reach_cnt2", 32'(count), 32'd2);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    checkOutput("abort_count", 32'(count), 32'd0);
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_core_reset", 32'(core_reset), 32'd1);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("abort_no_product", 32'(out_valid), 32'd0);
    applyStimulus(4'd3, 4'd3, 8'd9, 0);

    for (int n = 0; n < 20; n++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      applyStimulus(ra, rb, refProduct(ra, rb), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
